axis_cmd_gen_s2mm: RTL and testbench

AXIS_CMD_GEN_S2MM -- requirements
Module: axis_cmd_gen_s2mm

---
 rtl/axis_cmd_gen_s2mm_if.sv | 29 ++
 rtl/axis_cmd_gen_s2mm.sv | 194 +++++++++++++++++++
 tb/tb_axis_cmd_gen_s2mm.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_cmd_gen_s2mm_if.sv
// Command/status stream bundle between the S2MM command generator and a datamover.
// Both streams use AXI-Stream valid/ready: a beat transfers on a clock edge where
// valid and ready are both high; once valid rises, data holds and valid stays high until that edge.
interface axis_cmd_gen_s2mm_if;
    logic [71:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic [7:0]  s_axis_sts_tdata;
    logic        s_axis_sts_tvalid;
    logic        s_axis_sts_tready;

    modport master (
        output m_axis_cmd_tdata,
        output m_axis_cmd_tvalid,
        input  m_axis_cmd_tready,
        input  s_axis_sts_tdata,
        input  s_axis_sts_tvalid,
        output s_axis_sts_tready
    );

    modport slave (
        input  m_axis_cmd_tdata,
        input  m_axis_cmd_tvalid,
        output m_axis_cmd_tready,
        output s_axis_sts_tdata,
        output s_axis_sts_tvalid,
        input  s_axis_sts_tready
    );
endinterface

// File: rtl/axis_cmd_gen_s2mm.sv
// Generates datamover S2MM write commands that cover a capture buffer in PACKET_SIZE chunks,
// optionally looping as a ring buffer, while bounding the number of commands awaiting status.
module axis_cmd_gen_s2mm #(
    parameter int PACKET_SIZE     = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_cmd_gen_s2mm_if.master        axis,
    input  logic                       write_start,
    input  logic                       write_stop,
    input  logic                       wrap_en,
    input  logic [31:0]                base_addr,
    input  logic [31:0]                cap_size,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [7:0]                 err_status,
    output logic [31:0]                current_addr,
    output logic [7:0]                 run_cycles,
    output logic [15:0]                cmd_count,
    output logic [1:0]                 state_dbg,
    output logic [7:0]                 outstanding_dbg
);

    localparam int          OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] PKT = 32'(PACKET_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t        state;
    logic          start_q;
    logic [31:0]   base_q;
    logic [31:0]   cap_q;
    logic [31:0]   addr;
    logic [31:0]   remaining;
    logic [3:0]    tag;
    logic [OW-1:0] outstanding;
    logic          stop_pend;
    logic [71:0]   cmd_tdata;
    logic          cmd_tvalid;

    logic          cmd_hs;
    logic          sts_hs;
    logic          sts_bad;
    logic          in_run;
    logic          start_edge;
    logic          cur_eof;
    logic          halt;
    logic          wrap_now;
    logic          hold;
    logic [31:0]   cont_addr;
    logic [31:0]   cont_rem;
    logic [31:0]   src_addr;
    logic [31:0]   src_rem;
    logic [22:0]   src_btt;
    logic          src_eof;
    logic [3:0]    tag_src;
    logic [71:0]   new_cmd;
    logic [OW-1:0] out_next;

    assign axis.m_axis_cmd_tdata  = cmd_tdata;
    assign axis.m_axis_cmd_tvalid = cmd_tvalid;
    assign axis.s_axis_sts_tready = 1'b1;
    assign state_dbg              = state;
    assign outstanding_dbg        = 8'(outstanding);

    assign cmd_hs     = cmd_tvalid & axis.m_axis_cmd_tready;
    assign sts_hs     = axis.s_axis_sts_tvalid;
    assign sts_bad    = sts_hs & (~axis.s_axis_sts_tdata[7] | (|axis.s_axis_sts_tdata[6:4]));
    assign in_run     = (state == S_ISSUE) || (state == S_DRAIN);
    assign start_edge = write_start & ~start_q;
    assign cur_eof    = cmd_tdata[30];
    assign hold       = cmd_tvalid & ~axis.m_axis_cmd_tready;
    // Any stop or error source, including ones arriving this very cycle.
    assign halt       = stop_pend | write_stop | err | sts_bad;
    assign wrap_now   = cmd_hs & cur_eof & wrap_en & ~halt;

    assign cont_addr  = addr + {9'd0, cmd_tdata[22:0]};
    assign cont_rem   = remaining - {9'd0, cmd_tdata[22:0]};

    // Next command is built from post-handshake pointers so commands can go back to back.
    always_comb begin
        src_addr = addr;
        src_rem  = remaining;
        tag_src  = tag;
        if (cmd_hs) begin
            src_addr = wrap_now ? base_q : cont_addr;
            src_rem  = wrap_now ? cap_q  : cont_rem;
            tag_src  = tag + 4'd1;
        end
        src_btt = (src_rem < PKT) ? src_rem[22:0] : PKT[22:0];
        src_eof = (src_rem <= PKT);
        new_cmd = {4'd0, tag_src, src_addr, 1'b0, src_eof, 6'd0, 1'b1, src_btt};
    end

    always_comb begin
        out_next = outstanding;
        if (cmd_hs && !sts_hs) begin
            out_next = outstanding + OW'(1);
        end else if (!cmd_hs && sts_hs && outstanding != '0) begin
            out_next = outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            base_q       <= '0;
            cap_q        <= '0;
            addr         <= '0;
            remaining    <= '0;
            tag          <= '0;
            outstanding  <= '0;
            stop_pend    <= 1'b0;
            cmd_tdata    <= '0;
            cmd_tvalid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_status   <= '0;
            current_addr <= '0;
            run_cycles   <= '0;
            cmd_count    <= '0;
        end else begin
            start_q     <= write_start;
            done        <= 1'b0;
            outstanding <= out_next;

            if (sts_bad && in_run) begin
                err <= 1'b1;
                if (!err) err_status <= axis.s_axis_sts_tdata;
            end

            if (cmd_hs) begin
                cmd_tvalid   <= 1'b0;
                addr         <= src_addr;
                remaining    <= src_rem;
                tag          <= tag + 4'd1;
                cmd_count    <= cmd_count + 16'd1;
                current_addr <= cmd_tdata[63:32];
                if (cur_eof) run_cycles <= run_cycles + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge && cap_size != '0) begin
                        base_q    <= base_addr;
                        cap_q     <= cap_size;
                        addr      <= base_addr;
                        remaining <= cap_size;
                        stop_pend <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (write_stop) stop_pend <= 1'b1;
                    // A presented command is never withdrawn; decisions wait for its handshake.
                    if (!hold) begin
                        if (halt || (cmd_hs && cur_eof && !wrap_now)) begin
                            state <= S_DRAIN;
                        end else if (out_next < OW'(MAX_OUTSTANDING)) begin
                            cmd_tvalid <= 1'b1;
                            cmd_tdata  <= new_cmd;
                        end
                    end
                end
                S_DRAIN: begin
                    if (outstanding == '0) begin
                        busy <= 1'b0;
                        if (err || sts_bad) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_cmd_gen_s2mm.sv
// Directed bench for axis_cmd_gen_s2mm: linear scenarios with hand-computed command words.
module tb_axis_cmd_gen_s2mm;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_start;
  logic        write_stop;
  logic        wrap_en;
  logic [31:0] base_addr;
  logic [31:0] cap_size;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  err_status;
  logic [31:0] current_addr;
  logic [7:0]  run_cycles;
  logic [15:0] cmd_count;
  logic [1:0]  state_dbg;
  logic [7:0]  outstanding_dbg;

  axis_cmd_gen_s2mm_if bus ();

  axis_cmd_gen_s2mm #(.PACKET_SIZE(4096), .MAX_OUTSTANDING(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .axis            (bus),
    .write_start     (write_start),
    .write_stop      (write_stop),
    .wrap_en         (wrap_en),
    .base_addr       (base_addr),
    .cap_size        (cap_size),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .err_status      (err_status),
    .current_addr    (current_addr),
    .run_cycles      (run_cycles),
    .cmd_count       (cmd_count),
    .state_dbg       (state_dbg),
    .outstanding_dbg (outstanding_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // accepted commands and done pulses, sampled mid-cycle
  logic [71:0] acc_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (bus.m_axis_cmd_tvalid && bus.m_axis_cmd_tready) acc_q.push_back(bus.m_axis_cmd_tdata);
    if (done) done_cnt++;
  end

  // scoreboard
  logic [71:0] exp_q[$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    write_start = 1'b0;
    write_stop = 1'b0;
    bus.s_axis_sts_tvalid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic send_sts(input logic [7:0] b);
    bus.s_axis_sts_tdata = b;
    bus.s_axis_sts_tvalid = 1'b1;
    tick(1);
    bus.s_axis_sts_tvalid = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] base, input logic [31:0] cap, input logic wrap);
    base_addr = base;
    cap_size = cap;
    wrap_en = wrap;
    write_start = 1'b1;
    tick(1);
    write_start = 1'b0;
  endtask

  task automatic wait_cmds(input int n, input int budget);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic wait_done(input int prev, input int budget);
    int k = 0;
    while (done_cnt <= prev && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic wait_tvalid(input int budget);
    int k = 0;
    while (bus.m_axis_cmd_tvalid !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  int          b0;
  int          d0;
  int          stable;
  int          n_wrap;
  int          n_eof;
  logic [71:0] hold_exp;

  initial begin
    rst = 1'b1;
    write_start = 1'b0;
    write_stop = 1'b0;
    wrap_en = 1'b0;
    base_addr = '0;
    cap_size = '0;
    bus.m_axis_cmd_tready = 1'b1;
    bus.s_axis_sts_tdata = '0;
    bus.s_axis_sts_tvalid = 1'b0;

    // reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tvalid", bus.m_axis_cmd_tvalid, 0);
    check("rst_sts_tready", bus.s_axis_sts_tready, 1);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_current_addr", current_addr, 0);
    check("rst_err_status", err_status, 0);
    check("rst_state", state_dbg, 0);

    // basic pass: 10000 bytes -> 4096, 4096, 1808 (EOF)
    b0 = acc_q.size();
    d0 = done_cnt;
    exp_q.push_back(72'h00_10000000_00801000);
    exp_q.push_back(72'h01_10001000_00801000);
    exp_q.push_back(72'h02_10002000_40800710);
    bus.m_axis_cmd_tready = 1'b1;
    start_run(32'h1000_0000, 32'd10000, 1'b0);
    wait_cmds(b0 + 3, 30);
    check("basic_count", acc_q.size() - b0, 3);
    for (int i = 0; i < 3 && b0 + i < acc_q.size(); i++) check("basic_cmd", acc_q[b0 + i], exp_q[i]);
    exp_q.delete();
    check("basic_drain_state", state_dbg, 2);
    check("basic_outstanding", outstanding_dbg, 3);
    check("basic_busy", busy, 1);
    send_sts(8'h80);
    send_sts(8'h81);
    send_sts(8'h82);
    wait_done(d0, 20);
    tick(3);
    check("basic_done_pulses", done_cnt - d0, 1);
    check("basic_run_cycles", run_cycles, 1);
    check("basic_cmd_count", cmd_count, 3);
    check("basic_current_addr", current_addr, 32'h1000_2000);
    check("basic_idle", state_dbg, 0);
    check("basic_busy_end", busy, 0);

    // backpressure: tdata stable and tvalid held for 20 cycles
    do_reset();
    b0 = acc_q.size();
    d0 = done_cnt;
    bus.m_axis_cmd_tready = 1'b0;
    start_run(32'h2000_0000, 32'd4096, 1'b0);
    wait_tvalid(10);
    hold_exp = 72'h00_20000000_40801000;
    check("bp_first_tdata", bus.m_axis_cmd_tdata, hold_exp);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.m_axis_cmd_tvalid === 1'b1 && bus.m_axis_cmd_tdata === hold_exp) stable++;
    end
    check("bp_stable_cycles", stable, 20);
    check("bp_no_accept", acc_q.size() - b0, 0);
    bus.m_axis_cmd_tready = 1'b1;
    tick(1);
    check("bp_one_accept", acc_q.size() - b0, 1);
    check("bp_tvalid_after", bus.m_axis_cmd_tvalid, 0);
    send_sts(8'h80);
    wait_done(d0, 20);
    check("bp_done", done_cnt - d0, 1);

    // outstanding limit, then simultaneous command + status handshakes
    do_reset();
    b0 = acc_q.size();
    d0 = done_cnt;
    start_run(32'h0000_0000, 32'd32768, 1'b0);
    tick(20);
    check("lim_count", acc_q.size() - b0, 4);
    check("lim_tvalid", bus.m_axis_cmd_tvalid, 0);
    check("lim_outstanding", outstanding_dbg, 4);
    send_sts(8'h80);
    check("lim_fifth_tvalid", bus.m_axis_cmd_tvalid, 1);
    check("lim_fifth_tdata", bus.m_axis_cmd_tdata, 72'h04_00004000_00801000);
    check("lim_out_after_sts", outstanding_dbg, 3);
    send_sts(8'h81);
    check("sim_hs_outstanding", outstanding_dbg, 3);
    check("sim_hs_count", acc_q.size() - b0, 5);
    tick(1);
    check("lim_sixth_count", acc_q.size() - b0, 6);
    check("lim_sixth_outstanding", outstanding_dbg, 4);
    check("lim_sixth_tvalid", bus.m_axis_cmd_tvalid, 0);
    write_stop = 1'b1;
    tick(1);
    write_stop = 1'b0;
    check("lim_stop_drain", state_dbg, 2);
    for (int i = 2; i < 6; i++) send_sts(8'h80 | 8'(i));
    wait_done(d0, 20);
    check("lim_done", done_cnt - d0, 1);
    check("lim_cmd_count", cmd_count, 6);
    check("lim_run_cycles", run_cycles, 0);

    // ring-buffer mode: same SADDR, TAG wrapping 0..15, 0..
    do_reset();
    b0 = acc_q.size();
    d0 = done_cnt;
    start_run(32'h3000_0000, 32'd4096, 1'b1);
    for (int i = 0; i < 40; i++) send_sts(8'h80);
    write_stop = 1'b1;
    tick(1);
    write_stop = 1'b0;
    for (int i = 0; i < 4; i++) send_sts(8'h80);
    wait_done(d0, 20);
    tick(3);
    n_wrap = acc_q.size() - b0;
    n_eof = 0;
    for (int i = 0; i < n_wrap; i++) if (acc_q[b0 + i][30]) n_eof++;
    check("wrap_enough_cmds", (n_wrap >= 17) ? 1 : 0, 1);
    for (int i = 0; i < n_wrap; i++)
      check("wrap_cmd", acc_q[b0 + i], {4'd0, 4'(i % 16), 32'h3000_0000, 32'h4080_1000});
    check("wrap_done", done_cnt - d0, 1);
    check("wrap_run_cycles", run_cycles, 8'(n_eof));
    check("wrap_cmd_count", cmd_count, 16'(n_wrap));
    check("wrap_idle", state_dbg, 0);
    tick(5);
    check("wrap_no_more_cmds", acc_q.size() - b0, n_wrap);

    // SLVERR on the 2nd command
    do_reset();
    b0 = acc_q.size();
    d0 = done_cnt;
    start_run(32'h4000_0000, 32'd40960, 1'b0);
    tick(20);
    send_sts(8'h80);
    tick(3);
    check("err_pre_count", acc_q.size() - b0, 5);
    if (acc_q.size() >= b0 + 5) check("err_fifth_cmd", acc_q[b0 + 4], 72'h04_40004000_00801000);
    send_sts(8'h40);
    check("err_flag", err, 1);
    check("err_status", err_status, 8'h40);
    check("err_drain_state", state_dbg, 2);
    check("err_tvalid", bus.m_axis_cmd_tvalid, 0);
    send_sts(8'h20);
    send_sts(8'h80);
    send_sts(8'h80);
    tick(3);
    check("err_state", state_dbg, 3);
    check("err_busy", busy, 0);
    check("err_status_first", err_status, 8'h40);
    check("err_no_done", done_cnt - d0, 0);
    check("err_no_more_cmds", acc_q.size() - b0, 5);
    start_run(32'h5000_0000, 32'd4096, 1'b0);
    tick(5);
    check("err_start_ignored", state_dbg, 3);
    check("err_start_no_cmd", acc_q.size() - b0, 5);

    // zero-size start is ignored
    do_reset();
    b0 = acc_q.size();
    start_run(32'h6000_0000, 32'd0, 1'b0);
    tick(5);
    check("cap0_busy", busy, 0);
    check("cap0_tvalid", bus.m_axis_cmd_tvalid, 0);
    check("cap0_state", state_dbg, 0);

    // reset mid-run drops tvalid and stops issuing
    bus.m_axis_cmd_tready = 1'b0;
    start_run(32'h7000_0000, 32'd32768, 1'b0);
    wait_tvalid(10);
    check("mid_tvalid_up", bus.m_axis_cmd_tvalid, 1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_tvalid", bus.m_axis_cmd_tvalid, 0);
    rst = 1'b0;
    bus.m_axis_cmd_tready = 1'b1;
    tick(5);
    check("mid_after_tvalid", bus.m_axis_cmd_tvalid, 0);
    check("mid_after_busy", busy, 0);
    check("mid_after_cmds", acc_q.size() - b0, 0);
    check("mid_after_count", cmd_count, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
